// File: rtl/wb_dma_mem_arbiter_pkg.sv
// Shared definitions for the DMA/host memory arbiter: widths, FSM encoding,
// master indices and the Wishbone request payload.
package wb_dma_mem_arbiter_pkg;

  localparam int unsigned DAT_W = 32;
  localparam int unsigned ADR_W = 32;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_e;

  localparam logic MST_0 = 1'b0;
  localparam logic MST_1 = 1'b1;

  typedef struct packed {
    logic             we;
    logic             stb;
    logic             cyc;
    logic [SEL_W-1:0] sel;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/wb_dma_mem_arbiter_if.sv
// Bus bundle between two Wishbone masters, the arbiter and the shared memory.
// slave = arbiter view, master = environment view (masters plus memory).
interface wb_dma_mem_arbiter_if;
  import wb_dma_mem_arbiter_pkg::*;

  logic             m0_i_we, m0_i_stb, m0_i_cyc;
  logic [SEL_W-1:0] m0_i_sel;
  logic [ADR_W-1:0] m0_i_adr;
  logic [DAT_W-1:0] m0_i_dat;
  logic             m0_o_ack;
  logic [DAT_W-1:0] m0_o_dat;
  logic             m0_o_int;

  logic             m1_i_we, m1_i_stb, m1_i_cyc;
  logic [SEL_W-1:0] m1_i_sel;
  logic [ADR_W-1:0] m1_i_adr;
  logic [DAT_W-1:0] m1_i_dat;
  logic             m1_o_ack;
  logic [DAT_W-1:0] m1_o_dat;
  logic             m1_o_int;

  logic             s_o_we, s_o_stb, s_o_cyc;
  logic [SEL_W-1:0] s_o_sel;
  logic [ADR_W-1:0] s_o_adr;
  logic [DAT_W-1:0] s_o_dat;
  logic [DAT_W-1:0] s_i_dat;
  logic             s_i_ack, s_i_int;

  modport slave (
    input  m0_i_we, m0_i_stb, m0_i_cyc, m0_i_sel, m0_i_adr, m0_i_dat,
    output m0_o_ack, m0_o_dat, m0_o_int,
    input  m1_i_we, m1_i_stb, m1_i_cyc, m1_i_sel, m1_i_adr, m1_i_dat,
    output m1_o_ack, m1_o_dat, m1_o_int,
    output s_o_we, s_o_stb, s_o_cyc, s_o_sel, s_o_adr, s_o_dat,
    input  s_i_dat, s_i_ack, s_i_int
  );

  modport master (
    output m0_i_we, m0_i_stb, m0_i_cyc, m0_i_sel, m0_i_adr, m0_i_dat,
    input  m0_o_ack, m0_o_dat, m0_o_int,
    output m1_i_we, m1_i_stb, m1_i_cyc, m1_i_sel, m1_i_adr, m1_i_dat,
    input  m1_o_ack, m1_o_dat, m1_o_int,
    input  s_o_we, s_o_stb, s_o_cyc, s_o_sel, s_o_adr, s_o_dat,
    output s_i_dat, s_i_ack, s_i_int
  );

endinterface

// File: rtl/wb_arb_timeout.sv
// Stall watchdog: counts granted cycles with stb high and no ack, flags the
// cycle on which the limit is hit and emits a registered one-cycle pulse.
module wb_arb_timeout
  import wb_dma_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic stall,
  output logic expire_c,
  output logic pulse
);

  localparam bit               ENABLE = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LIMIT  = ENABLE ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [CNT_W-1:0] cnt_q;

  assign expire_c = ENABLE && stall && (cnt_q == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= expire_c;
      if (clr)        cnt_q <= '0;
      else if (stall) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_dma_mem_arbiter.sv
// Two-master Wishbone arbiter in front of a shared memory: alternating
// priority on contention, cycle-long grants, and a stall timeout that revokes.
module wb_dma_mem_arbiter
  import wb_dma_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_dma_mem_arbiter_if.slave  bus,
  output logic [1:0]           o_grant,
  output logic                 o_timeout,
  output logic                 o_timeout_id
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] mask_q, mask_d;
  logic       tid_d;
  logic [1:0] want;
  logic       stall, expire_c, cnt_clr;
  wb_req_t    req0, req1, sreq;

  assign req0 = '{we: bus.m0_i_we, stb: bus.m0_i_stb, cyc: bus.m0_i_cyc,
                  sel: bus.m0_i_sel, adr: bus.m0_i_adr, dat: bus.m0_i_dat};
  assign req1 = '{we: bus.m1_i_we, stb: bus.m1_i_stb, cyc: bus.m1_i_cyc,
                  sel: bus.m1_i_sel, adr: bus.m1_i_adr, dat: bus.m1_i_dat};

  // A revoked master stays out of arbitration until it drops cyc.
  assign want = {bus.m1_i_cyc, bus.m0_i_cyc} & ~mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_q       <= MST_1;
      mask_q       <= '0;
      o_timeout_id <= MST_0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      mask_q       <= mask_d;
      o_timeout_id <= tid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    tid_d   = o_timeout_id;
    mask_d  = mask_q & {bus.m1_i_cyc, bus.m0_i_cyc};
    unique case (state_q)
      ST_IDLE: begin
        if (want[0] && want[1]) state_d = (last_q == MST_1) ? ST_GRANT0 : ST_GRANT1;
        else if (want[0])       state_d = ST_GRANT0;
        else if (want[1])       state_d = ST_GRANT1;
      end
      ST_GRANT0: begin
        if (!bus.m0_i_cyc) begin
          last_d  = MST_0;
          state_d = want[1] ? ST_GRANT1 : ST_IDLE;
        end else if (expire_c) begin
          last_d    = MST_0;
          mask_d[0] = 1'b1;
          tid_d     = MST_0;
          state_d   = ST_IDLE;
        end
      end
      ST_GRANT1: begin
        if (!bus.m1_i_cyc) begin
          last_d  = MST_1;
          state_d = want[0] ? ST_GRANT0 : ST_IDLE;
        end else if (expire_c) begin
          last_d    = MST_1;
          mask_d[1] = 1'b1;
          tid_d     = MST_1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Combinational steering of request and response paths by the current grant.
  always_comb begin
    sreq         = '0;
    bus.m0_o_ack = 1'b0;
    bus.m0_o_dat = '0;
    bus.m1_o_ack = 1'b0;
    bus.m1_o_dat = '0;
    unique case (state_q)
      ST_GRANT0: begin
        sreq         = req0;
        bus.m0_o_ack = bus.s_i_ack;
        bus.m0_o_dat = bus.s_i_dat;
      end
      ST_GRANT1: begin
        sreq         = req1;
        bus.m1_o_ack = bus.s_i_ack;
        bus.m1_o_dat = bus.s_i_dat;
      end
      default: ;
    endcase
  end

  assign bus.s_o_we   = sreq.we;
  assign bus.s_o_stb  = sreq.stb;
  assign bus.s_o_cyc  = sreq.cyc;
  assign bus.s_o_sel  = sreq.sel;
  assign bus.s_o_adr  = sreq.adr;
  assign bus.s_o_dat  = sreq.dat;
  assign bus.m0_o_int = bus.s_i_int;
  assign bus.m1_o_int = bus.s_i_int;

  assign o_grant = {state_q == ST_GRANT1, state_q == ST_GRANT0};

  assign stall   = sreq.cyc & sreq.stb & ~bus.s_i_ack;
  assign cnt_clr = (state_d != state_q) | bus.s_i_ack;

  wb_arb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .stall    (stall),
    .expire_c (expire_c),
    .pulse    (o_timeout)
  );

endmodule

// File: tb/tb_wb_dma_mem_arbiter.sv
// Randomized bench for wb_dma_mem_arbiter against a transaction-level
// ownership model, plus directed scenarios for grant, handover, timeout, reset.
module tb_wb_dma_mem_arbiter;

  localparam int TO = 16;

  logic       clk;
  logic       rst_n;
  logic [1:0] o_grant;
  logic       o_timeout, o_timeout_id;

  wb_dma_mem_arbiter_if bus();

  wb_dma_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .o_grant      (o_grant),
    .o_timeout    (o_timeout),
    .o_timeout_id (o_timeout_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the memory (-1 none), who last owned it,
  // who is banned, and how many stalled beats the owner has accumulated.
  int own, last, stalls;
  bit banned [2];
  bit tout, tid;
  int n_own, n_last, n_stalls;
  bit n_banned [2];
  bit n_tout, n_tid;

  function automatic bit cyc_of(int i);
    return (i == 1) ? bus.m1_i_cyc : bus.m0_i_cyc;
  endfunction

  function automatic bit stb_of(int i);
    return (i == 1) ? bus.m1_i_stb : bus.m0_i_stb;
  endfunction

  task automatic model_reset();
    own = -1; last = 1; stalls = 0; banned[0] = 0; banned[1] = 0; tout = 0; tid = 0;
  endtask

  task automatic model_next();
    bit want [2];
    bit ack;
    ack = bus.s_i_ack;
    for (int i = 0; i < 2; i++) begin
      want[i]     = cyc_of(i) && !banned[i];
      n_banned[i] = banned[i] && cyc_of(i);
    end
    n_own = own; n_last = last; n_tout = 0; n_tid = tid;
    if (own < 0) begin
      if (want[0] && want[1]) n_own = 1 - last;
      else if (want[0])       n_own = 0;
      else if (want[1])       n_own = 1;
    end else if (!cyc_of(own)) begin
      n_last = own;
      n_own  = want[1-own] ? 1 - own : -1;
    end else if (stb_of(own) && !ack && (stalls + 1 == TO)) begin
      n_own = -1; n_last = own; n_banned[own] = 1; n_tout = 1; n_tid = (own == 1);
    end
    if (n_own != own || ack)                          n_stalls = 0;
    else if (own >= 0 && cyc_of(own) && stb_of(own))  n_stalls = stalls + 1;
    else                                              n_stalls = stalls;
  endtask

  task automatic model_commit();
    own = n_own; last = n_last; stalls = n_stalls; tout = n_tout; tid = n_tid;
    banned[0] = n_banned[0]; banned[1] = n_banned[1];
  endtask

  task automatic check_model();
    logic        e_we, e_stb, e_cyc;
    logic [3:0]  e_sel;
    logic [31:0] e_adr, e_dat;
    e_we = 0; e_stb = 0; e_cyc = 0; e_sel = 0; e_adr = 0; e_dat = 0;
    if (own == 0) begin
      e_we = bus.m0_i_we; e_stb = bus.m0_i_stb; e_cyc = bus.m0_i_cyc;
      e_sel = bus.m0_i_sel; e_adr = bus.m0_i_adr; e_dat = bus.m0_i_dat;
    end else if (own == 1) begin
      e_we = bus.m1_i_we; e_stb = bus.m1_i_stb; e_cyc = bus.m1_i_cyc;
      e_sel = bus.m1_i_sel; e_adr = bus.m1_i_adr; e_dat = bus.m1_i_dat;
    end
    check("grant",   32'(o_grant), (own == 0) ? 32'd1 : (own == 1) ? 32'd2 : 32'd0);
    check("s_we",    32'(bus.s_o_we),  32'(e_we));
    check("s_stb",   32'(bus.s_o_stb), 32'(e_stb));
    check("s_cyc",   32'(bus.s_o_cyc), 32'(e_cyc));
    check("s_sel",   32'(bus.s_o_sel), 32'(e_sel));
    check("s_adr",   bus.s_o_adr, e_adr);
    check("s_dat",   bus.s_o_dat, e_dat);
    check("m0_ack",  32'(bus.m0_o_ack), 32'((own == 0) && bus.s_i_ack));
    check("m1_ack",  32'(bus.m1_o_ack), 32'((own == 1) && bus.s_i_ack));
    check("m0_dat",  bus.m0_o_dat, (own == 0) ? bus.s_i_dat : 32'd0);
    check("m1_dat",  bus.m1_o_dat, (own == 1) ? bus.s_i_dat : 32'd0);
    check("m0_int",  32'(bus.m0_o_int), 32'(bus.s_i_int));
    check("m1_int",  32'(bus.m1_o_int), 32'(bus.s_i_int));
    check("timeout", 32'(o_timeout), 32'(tout));
    check("tout_id", 32'(o_timeout_id), 32'(tid));
  endtask

  // Called mid-cycle: compare, predict, cross the edge, adopt the prediction.
  task automatic tick();
    check_model();
    model_next();
    @(posedge clk); #1;
    model_commit();
  endtask

  task automatic idle_inputs();
    bus.m0_i_we = 0; bus.m0_i_stb = 0; bus.m0_i_cyc = 0; bus.m0_i_sel = 0; bus.m0_i_adr = 0; bus.m0_i_dat = 0;
    bus.m1_i_we = 0; bus.m1_i_stb = 0; bus.m1_i_cyc = 0; bus.m1_i_sel = 0; bus.m1_i_adr = 0; bus.m1_i_dat = 0;
    bus.s_i_dat = 0; bus.s_i_ack = 0; bus.s_i_int = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.m0_i_cyc = 1; bus.m0_i_stb = 1; bus.s_i_ack = 1;
    #2; rst_n = 0; #1;
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_cyc",   32'(bus.s_o_cyc), 32'd0);
    check("rst_ack0",  32'(bus.m0_o_ack), 32'd0);
    check("rst_ack1",  32'(bus.m1_o_ack), 32'd0);
    check("rst_to",    32'(o_timeout), 32'd0);
    check("rst_tid",   32'(o_timeout_id), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    model_reset();
    rst_n = 1;
  endtask

  task automatic m_req(input int i, input bit cyc, input bit stb, input bit we);
    if (i == 0) begin bus.m0_i_cyc = cyc; bus.m0_i_stb = stb; bus.m0_i_we = we; end
    else        begin bus.m1_i_cyc = cyc; bus.m1_i_stb = stb; bus.m1_i_we = we; end
  endtask

  int burst [2];

  task automatic rand_inputs(input int ack_pct, input int maxb);
    for (int i = 0; i < 2; i++) begin
      if (burst[i] == 0 && $urandom_range(3) == 0) burst[i] = $urandom_range(maxb, 1);
      m_req(i, burst[i] > 0, (burst[i] > 0) && ($urandom_range(3) != 0), 1'($urandom_range(1)));
      if (burst[i] > 0) burst[i]--;
    end
    bus.m0_i_sel = 4'($urandom); bus.m0_i_adr = $urandom; bus.m0_i_dat = $urandom;
    bus.m1_i_sel = 4'($urandom); bus.m1_i_adr = $urandom; bus.m1_i_dat = $urandom;
    bus.s_i_dat  = $urandom;
    bus.s_i_ack  = ($urandom_range(99) < ack_pct);
    bus.s_i_int  = 1'($urandom_range(1));
  endtask

  initial begin
    int seen;
    logic [1:0] g_after;
    logic [31:0] v;
    rst_n = 1;
    idle_inputs();
    model_reset();

    // Single m0 write: one-cycle latency, address passed, ack to m0 only.
    do_reset();
    m_req(0, 1, 1, 1); bus.m0_i_adr = 32'h100; bus.m0_i_dat = 32'hDEADBEEF; bus.m0_i_sel = 4'hF;
    #2; check("lat_idle_cyc", 32'(bus.s_o_cyc), 32'd0); tick();
    bus.s_i_ack = 1;
    #2;
    check("w_cyc",  32'(bus.s_o_cyc), 32'd1);
    check("w_adr",  bus.s_o_adr, 32'h100);
    check("w_dat",  bus.s_o_dat, 32'hDEADBEEF);
    check("w_g",    32'(o_grant), 32'd1);
    check("w_ack0", 32'(bus.m0_o_ack), 32'd1);
    check("w_ack1", 32'(bus.m1_o_ack), 32'd0);
    tick();
    bus.s_i_ack = 0; m_req(0, 0, 0, 0); #2; tick(); #2; tick();

    // Simultaneous request after reset, then direct handover without bubble.
    do_reset();
    m_req(0, 1, 1, 0); m_req(1, 1, 1, 0);
    #2; tick();
    #2; check("both_m0_first", 32'(o_grant), 32'd1);
    tick();
    m_req(0, 0, 0, 0);
    #2; tick();
    #2; check("handover_m1", 32'(o_grant), 32'd2); tick();
    m_req(1, 0, 0, 0); #2; tick(); #2; tick();

    // m1 4-beat read while m0 keeps requesting.
    do_reset();
    m_req(1, 1, 1, 0); #2; tick();
    m_req(0, 1, 1, 1); #2; tick();
    for (int b = 0; b < 4; b++) begin
      v = $urandom; bus.s_i_dat = v; bus.s_i_ack = 1;
      #2;
      check("rd_g",    32'(o_grant), 32'd2);
      check("rd_dat1", bus.m1_o_dat, v);
      check("rd_dat0", bus.m0_o_dat, 32'd0);
      tick();
      bus.s_i_ack = 0; #2; check("rd_hold", 32'(o_grant), 32'd2); tick();
    end
    m_req(1, 0, 0, 0); #2; tick();
    #2; check("rd_then_m0", 32'(o_grant), 32'd1); tick();
    m_req(0, 0, 0, 0); #2; tick(); #2; tick();

    // Stall timeout on m0 with m1 waiting.
    do_reset();
    m_req(0, 1, 1, 0); m_req(1, 1, 1, 0);
    seen = -1; g_after = 2'b00;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (o_timeout && seen < 0) seen = c;
      if (seen >= 0 && c == seen + 1) g_after = o_grant;
      tick();
    end
    check("to_cycle", 32'(seen), 32'd17);
    check("to_m1",    32'(g_after), 32'd2);
    m_req(1, 0, 0, 0); #2; tick();
    #2; check("m0_masked", 32'(o_grant), 32'd0); tick();
    m_req(0, 0, 0, 0); #2; tick();
    m_req(0, 1, 1, 0); #2; tick();
    #2; check("m0_regrant", 32'(o_grant), 32'd1); tick();
    m_req(0, 0, 0, 0); #2; tick(); #2; tick();

    // Asynchronous reset in the middle of an m1 burst.
    do_reset();
    m_req(1, 1, 1, 0); #2; tick();
    for (int b = 0; b < 2; b++) begin bus.s_i_ack = 1; bus.s_i_dat = $urandom; #2; tick(); end
    bus.s_i_ack = 1;
    #2; rst_n = 0; #1;
    check("mr_cyc",   32'(bus.s_o_cyc), 32'd0);
    check("mr_grant", 32'(o_grant), 32'd0);
    check("mr_ack1",  32'(bus.m1_o_ack), 32'd0);
    @(posedge clk); #1;
    model_reset(); rst_n = 1;
    bus.s_i_ack = 0; m_req(0, 1, 1, 0); m_req(1, 1, 1, 0);
    #2; tick();
    #2; check("mr_m0_first", 32'(o_grant), 32'd1); tick();

    // Randomized traffic: moderate acks, then starved slave to force timeouts.
    do_reset();
    burst[0] = 0; burst[1] = 0;
    for (int c = 0; c < 600; c++) begin rand_inputs(50, 8);  #2; tick(); end
    for (int c = 0; c < 600; c++) begin rand_inputs(3, 40);  #2; tick(); end
    for (int c = 0; c < 300; c++) begin rand_inputs(0, 30);  #2; tick(); end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_dma_mem_arbiter.md
WB_DMA_MEM_ARBITER -- requirements
Module: wb_dma_mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1024, stall cycles before a grant is forcibly revoked; 0 disables the timeout.
REQ-002 clk  input  1  single clock, all logic rising-edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 m0_i_we, m0_i_stb, m0_i_cyc  input  1 each  master 0 Wishbone controls (DMA writer side).
REQ-005 m0_i_sel  input  4; m0_i_adr, m0_i_dat  input  32  master 0 select/address/write data.
REQ-006 m0_o_ack  output  1; m0_o_dat  output  32; m0_o_int  output  1  master 0 return path.
REQ-007 m1_* ports  identical set to REQ-004..006  master 1 (host/CPU side).
REQ-008 s_o_we, s_o_stb, s_o_cyc  output  1; s_o_sel  output  4; s_o_adr, s_o_dat  output  32  shared memory slave request.
REQ-009 s_i_dat  input  32; s_i_ack, s_i_int  input  1  shared memory slave response.
REQ-010 o_grant  output  2  one-hot current grant (bit0 = m0, bit1 = m1), 00 when idle.
REQ-011 o_timeout  output  1  one-cycle pulse on forced revoke; o_timeout_id  output  1  master that was revoked.

Function
REQ-012 FSM states IDLE, GRANT0, GRANT1, registered.
REQ-013 IDLE: only one cycle asserted -> grant that master next cycle; both asserted -> grant the master not in r_last; neither -> stay.
REQ-014 Grant latency: s_o_cyc asserts exactly one cycle after a requesting m*_i_cyc is seen in IDLE.
REQ-015 While GRANTn: s_o_* = mn_i_* combinationally; mn_o_ack = s_i_ack, mn_o_dat = s_i_dat; non-granted master sees ack 0 and dat 0.
REQ-016 IDLE: all s_o_* driven 0; no ack to either master.
REQ-017 Grant held for whole mn_i_cyc assertion (bursts/RMW uninterrupted); stb toggling does not release.
REQ-018 On granted mn_i_cyc low: other master's cyc high -> move directly to its grant next cycle (no IDLE bubble); else -> IDLE; r_last <= n.
REQ-019 Stall counter (32 bits): cleared on grant change and on every s_i_ack; increments each granted cycle with stb high and s_i_ack low.
REQ-020 Counter reaching TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES != 0 -> next cycle: state IDLE, o_timeout = 1 for one cycle, o_timeout_id = n, r_last = n.
REQ-021 Revoked master masked from arbitration until its cyc deasserts; it never receives the stalled ack.
REQ-022 s_i_int fanned to m0_o_int and m1_o_int regardless of grant.
REQ-023 s_i_ack in IDLE ignored; s_i_ack on the cycle the grant ends is routed to the releasing master only.

Reset
REQ-024 rst_n low asynchronously forces: state IDLE, o_grant 00, all s_o_* 0, both acks 0, counter 0, o_timeout 0, o_timeout_id 0, r_last = 1 (m0 wins first contention), both masks cleared.
REQ-025 Reset mid-transaction drops s_o_cyc immediately; after release, arbitration restarts from IDLE on the first rising edge.

Structure
REQ-026 Shared package: state encoding constants (IDLE/GRANT0/GRANT1) and master-index constants.
REQ-027 One sub-module natural: wb_arb_timeout (stall counter plus compare, pulse output); master/slave muxing stays in the top.

Verification
REQ-028 Only m0 cyc/stb, write adr 0x100 data 0xDEADBEEF -> s_o_cyc one cycle later, s_o_adr 0x100, ack to m0 only, o_grant 01.
REQ-029 Both cyc rise same cycle after reset -> m0 granted first; m0 drops cyc with m1 still asserted -> o_grant 10 next cycle, no IDLE cycle.
REQ-030 m1 holds cyc over 4-beat read, m0 requesting throughout -> no grant change until m1 cyc low; all 4 s_i_dat values reach m1_o_dat only.
REQ-031 TIMEOUT_CYCLES=16, slave never acks m0 -> o_timeout pulse after 16 stalled cycles, o_timeout_id 0, m1 granted if requesting, m0 ignored until its cyc drops.
REQ-032 rst_n low during m1 burst -> s_o_cyc, acks, o_grant 0 without clock edge; after release, both requesting -> m0 granted.
